can_rx_destuffer: RTL and testbench
===================================

Name: can_rx_destuffer

Overview:
- Receive-side CAN bit-stream stage for the tinycan design, directly downstream of the bit sampler.
- Consumes one sampled bus bit per strobe, removes stuff bits, detects stuff errors and runs the CRC-15 over the destuffed bits.
- Feeds destuffed bits, one cycle later, to the frame field decoder.

Parameters:
RUN_LEN, 5, identical-bit run length after which the next bit is a stuff bit
CRC_POLY, 15'h4599, CAN CRC-15 generator polynomial (x^15 term implicit)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
bit_in  input  1  sampled bus bit (0 = dominant)
bit_valid  input  1  one-cycle strobe qualifying bit_in
sof  input  1  qualifies the current bit_valid as the start-of-frame bit; restarts the frame
stuff_en  input  1  1 = destuffing/checking active (arbitration through CRC field), 0 = pass-through
bit_out  output  1  destuffed bit
bit_out_valid  output  1  one-cycle strobe qualifying bit_out
stuff_err  output  1  one-cycle pulse on a stuff violation
frame_active  output  1  high in RX state
crc  output  15  running CRC register
crc_zero  output  1  crc == 0

Behaviour:
- Reset (async assert, sync release): state IDLE, last_bit = 1, run_cnt = 0, crc = 0.
  - Output reset values: bit_out = 0, bit_out_valid = 0, stuff_err = 0, frame_active = 0, crc_zero = 1.
- Only cycles with bit_valid = 1 are processed; all other cycles hold state; bit_out_valid/stuff_err are 0.
- States:
  - IDLE: bits without sof ignored.
  - RX: normal processing.
  - ERR: all bits ignored, no outputs; left only via sof or reset.
  - sof with bit_valid in any state: enter RX, crc cleared to 0, run_cnt = 1, last_bit = bit_in.
    - The bit is passed to the output and included in the CRC (cleared value, then updated).
- RX, stuff_en = 1, run_cnt < RUN_LEN: pass bit.
  - run_cnt = (bit_in == last_bit) ? run_cnt + 1 : 1; last_bit = bit_in.
- RX, stuff_en = 1, run_cnt == RUN_LEN: stuff bit.
  - bit_in != last_bit: discard (no bit_out_valid, CRC unchanged); run_cnt = 1, last_bit = bit_in.
  - bit_in == last_bit: stuff_err pulse next cycle; state ERR; no bit_out_valid.
- RX, stuff_en = 0: pass bit; run_cnt = 0; last_bit = bit_in; no stuff check.
- Pass bit timing: bit_out/bit_out_valid registered, latency exactly 1 cycle from bit_valid.
- CRC update on each passed bit, in the same cycle as the output register update:
  - fb = bit_in ^ crc[14]; crc = {crc[13:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - crc/crc_zero reflect the update 1 cycle after bit_valid.
  - The bench clears stuff_en before CRC delimiter bits, so crc_zero is sampled after the last CRC bit.
- sof together with a stuff violation: sof wins (frame restart, no stuff_err).
- Back-to-back bit_valid on consecutive cycles is supported.

Optional Feature:
- Macro: CAN_DESTUFF_STATS_EN.
- Defined:
  - Adds output stuff_cnt [7:0]: counts discarded stuff bits, saturates at 8'hFF.
  - Cleared on reset and on sof.
- Undefined:
  - Port absent; no counter logic.

Test Plan:
1. sof with bit 0, then bits 0,0,0,0, then 1 (stuff_en = 1):
   - Response: five bit_out_valid pulses with bit_out = 0; sixth bit discarded; no stuff_err; stuff_cnt = 1 when enabled.
2. sof with bit 0, then five more 0s:
   - Response: five outputs; stuff_err pulses once, one cycle after the sixth bit; frame_active = 0.
   - Further bits produce no output until the next sof.
3. stuff_en = 0 after sof, then eight 1s:
   - Response: nine bit_out_valid pulses (SOF 0 plus eight 1s); stuff_err stays 0.
4. CRC check:
   - sof with bit 0 -> crc = 15'h0000.
   - Next bit 1 -> crc = 15'h4599, crc_zero = 0.
   - Feeding 15'h4599 MSB-first with stuff_en = 0 -> crc_zero = 1.
5. Bits 0,0,0 with bit_valid in IDLE without sof:
   - Response: no outputs; frame_active = 0.
   - A following sof starts a frame normally.
6. rst_n low mid-frame (run_cnt = 3):
   - Response: outputs immediately at reset values; frame_active = 0.
   - After release, bits ignored until sof.

Source files
------------

// File: rtl/can_rx_destuffer.sv
// CAN receive bit destuffer: removes stuff bits, flags stuff violations and runs CRC-15 on destuffed bits.
// Optional stuff-bit counter output is enabled by defining CAN_DESTUFF_STATS_EN.
module can_rx_destuffer #(
    parameter int          RUN_LEN  = 5,
    parameter logic [14:0] CRC_POLY = 15'h4599
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        sof,
    input  logic        stuff_en,
    output logic        bit_out,
    output logic        bit_out_valid,
    output logic        stuff_err,
    output logic        frame_active,
    output logic [14:0] crc,
    output logic        crc_zero
`ifdef CAN_DESTUFF_STATS_EN
    ,
    output logic [7:0]  stuff_cnt
`endif
);

    localparam int             CW      = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0]  RUN_MAX = CW'(RUN_LEN);
    localparam logic [CW-1:0]  RUN_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RX,
        ERR
    } state_t;

    state_t        state_q;
    logic          last_bit_q;
    logic [CW-1:0] run_cnt_q;
    logic [14:0]   crc_q;
    logic          bit_out_q;
    logic          bit_out_valid_q;
    logic          stuff_err_q;
    logic [14:0]   crc_d;
    logic [14:0]   crc_sof_d;

    // A start-of-frame bit is folded into a freshly cleared register, so only the feedback term survives.
    always_comb begin
        crc_d     = {crc_q[13:0], 1'b0} ^ ((bit_in ^ crc_q[14]) ? CRC_POLY : 15'h0000);
        crc_sof_d = bit_in ? CRC_POLY : 15'h0000;
    end

`ifdef CAN_DESTUFF_STATS_EN
    logic [7:0] stuff_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuff_cnt_q <= 8'h00;
        end else if (bit_valid && sof) begin
            stuff_cnt_q <= 8'h00;
        end else if (bit_valid && state_q == RX && stuff_en && run_cnt_q == RUN_MAX
                     && bit_in != last_bit_q && stuff_cnt_q != 8'hFF) begin
            stuff_cnt_q <= stuff_cnt_q + 8'h01;
        end
    end

    assign stuff_cnt = stuff_cnt_q;
`endif

    // Receive FSM; sof always restarts the frame, even over a pending stuff violation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            last_bit_q      <= 1'b1;
            run_cnt_q       <= '0;
            crc_q           <= 15'h0000;
            bit_out_q       <= 1'b0;
            bit_out_valid_q <= 1'b0;
            stuff_err_q     <= 1'b0;
        end else begin
            bit_out_valid_q <= 1'b0;
            stuff_err_q     <= 1'b0;
            if (bit_valid) begin
                if (sof) begin
                    state_q         <= RX;
                    crc_q           <= crc_sof_d;
                    run_cnt_q       <= RUN_ONE;
                    last_bit_q      <= bit_in;
                    bit_out_q       <= bit_in;
                    bit_out_valid_q <= 1'b1;
                end else if (state_q == RX) begin
                    if (!stuff_en) begin
                        run_cnt_q       <= '0;
                        last_bit_q      <= bit_in;
                        crc_q           <= crc_d;
                        bit_out_q       <= bit_in;
                        bit_out_valid_q <= 1'b1;
                    end else if (run_cnt_q == RUN_MAX) begin
                        if (bit_in != last_bit_q) begin
                            run_cnt_q  <= RUN_ONE;
                            last_bit_q <= bit_in;
                        end else begin
                            stuff_err_q <= 1'b1;
                            state_q     <= ERR;
                        end
                    end else begin
                        run_cnt_q       <= (bit_in == last_bit_q) ? run_cnt_q + RUN_ONE : RUN_ONE;
                        last_bit_q      <= bit_in;
                        crc_q           <= crc_d;
                        bit_out_q       <= bit_in;
                        bit_out_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bit_out       = bit_out_q;
    assign bit_out_valid = bit_out_valid_q;
    assign stuff_err     = stuff_err_q;
    assign frame_active  = (state_q == RX);
    assign crc           = crc_q;
    assign crc_zero      = (crc_q == 15'h0000);

endmodule

// File: tb/tb_can_rx_destuffer.sv
// Randomized and directed bench for can_rx_destuffer against a frame-level reference model.
// Build with CAN_DESTUFF_STATS_EN defined to also check the stuff-bit counter.
module tb_can_rx_destuffer;

    localparam int RUN_LEN = 5;
    localparam logic [15:0] GEN = 16'h8000 | 16'h4599;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_in = 1'b1;
    logic        bit_valid = 1'b0;
    logic        sof = 1'b0;
    logic        stuff_en = 1'b1;
    logic        bit_out;
    logic        bit_out_valid;
    logic        stuff_err;
    logic        frame_active;
    logic [14:0] crc;
    logic        crc_zero;
`ifdef CAN_DESTUFF_STATS_EN
    logic [7:0]  stuff_cnt;
`endif

    int checkCount = 0;
    int errCount = 0;

    // Reference model: frame state, raw bits of the current run window, and destuffed message since sof.
    int   mState = 0;
    bit   runQ[$];
    bit   msg[$];
    logic expBit = 1'b0;
    logic expValid = 1'b0;
    logic expErr = 1'b0;
    int   expCnt = 0;
    logic [14:0] expCrc = 15'h0000;

    can_rx_destuffer dut (
        .clk(clk),
        .rst_n(rst_n),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .sof(sof),
        .stuff_en(stuff_en),
        .bit_out(bit_out),
        .bit_out_valid(bit_out_valid),
        .stuff_err(stuff_err),
        .frame_active(frame_active),
        .crc(crc),
        .crc_zero(crc_zero)
`ifdef CAN_DESTUFF_STATS_EN
        ,
        .stuff_cnt(stuff_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // CRC as remainder of msg(x) * x^15 divided by the generator polynomial.
    function automatic logic [14:0] crcOfMsg();
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < msg.size() + 15; i++) begin
            r = {r[14:0], (i < msg.size()) ? msg[i] : 1'b0};
            if (r[15]) r = r ^ GEN;
        end
        return r[14:0];
    endfunction

    function automatic bit atStuffPosition();
        if (runQ.size() < RUN_LEN) return 1'b0;
        for (int i = 1; i < RUN_LEN; i++)
            if (runQ[runQ.size() - 1 - i] != runQ[runQ.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelPass(input bit b);
        msg.push_back(b);
        expValid = 1'b1;
        expBit = b;
        expCrc = crcOfMsg();
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".valid"}, 32'(bit_out_valid), 32'(expValid));
        checkOutput({tag, ".bit"}, 32'(bit_out), 32'(expBit));
        checkOutput({tag, ".stuffErr"}, 32'(stuff_err), 32'(expErr));
        checkOutput({tag, ".active"}, 32'(frame_active), 32'(mState == 1));
        checkOutput({tag, ".crc"}, 32'(crc), 32'(expCrc));
        checkOutput({tag, ".crcZero"}, 32'(crc_zero), 32'(expCrc == 15'h0000));
`ifdef CAN_DESTUFF_STATS_EN
        checkOutput({tag, ".stuffCnt"}, 32'(stuff_cnt), 32'(expCnt));
`endif
    endtask

    // Drive one cycle of inputs, advance the model, and check the registered response.
    task automatic applyStimulus(input string tag, input logic v, input logic s, input logic se, input logic b);
        bit_valid = v;
        sof = s;
        stuff_en = se;
        bit_in = b;
        expValid = 1'b0;
        expErr = 1'b0;
        if (v) begin
            if (s) begin
                mState = 1;
                msg.delete();
                runQ.delete();
                runQ.push_back(b);
                expCnt = 0;
                modelPass(b);
            end else if (mState == 1) begin
                if (!se) begin
                    runQ.delete();
                    modelPass(b);
                end else if (atStuffPosition()) begin
                    if (b != runQ[runQ.size() - 1]) begin
                        runQ.delete();
                        runQ.push_back(b);
                        if (expCnt < 255) expCnt++;
                    end else begin
                        expErr = 1'b1;
                        mState = 2;
                    end
                end else begin
                    runQ.push_back(b);
                    if (runQ.size() > RUN_LEN) void'(runQ.pop_front());
                    modelPass(b);
                end
            end
        end
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic modelReset();
        mState = 0;
        runQ.delete();
        msg.delete();
        expBit = 1'b0;
        expValid = 1'b0;
        expErr = 1'b0;
        expCnt = 0;
        expCrc = 15'h0000;
    endtask

    initial begin
        logic [14:0] crcWord;
        logic        lastBit;
        logic        se;
        int          frameLen;

        modelReset();
        #12;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stuff bit after five dominant bits is discarded.
        applyStimulus("t1", 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus("t1", 1, 0, 1, 0);
        applyStimulus("t1stuff", 1, 0, 1, 1);
        checkOutput("t1.noOut", 32'(bit_out_valid), 32'd0);

        // Sixth identical bit is a stuff violation.
        applyStimulus("t2", 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus("t2", 1, 0, 1, 0);
        applyStimulus("t2viol", 1, 0, 1, 0);
        checkOutput("t2.err", 32'(stuff_err), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus("t2after", 1, 0, 1, 1);

        // Pass-through with stuffing disabled.
        applyStimulus("t3", 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus("t3", 1, 0, 0, 1);

        // CRC of a short message followed by its own CRC gives zero.
        applyStimulus("t4sof", 1, 1, 1, 0);
        checkOutput("t4.crc0", 32'(crc), 32'h0000);
        applyStimulus("t4one", 1, 0, 1, 1);
        checkOutput("t4.crcPoly", 32'(crc), 32'h4599);
        crcWord = 15'h4599;
        for (int i = 14; i >= 0; i--) applyStimulus("t4tail", 1, 0, 0, crcWord[i]);
        checkOutput("t4.crcZero", 32'(crc_zero), 32'd1);

        // Idle bits without sof are ignored; gaps hold state.
        applyStimulus("t5gap", 0, 0, 1, 0);
        mState = 0;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("t5rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus("t5idle", 1, 0, 1, 0);
        applyStimulus("t5sof", 1, 1, 1, 0);

        // Reset mid-frame after three identical bits.
        applyStimulus("t6", 1, 0, 1, 0);
        applyStimulus("t6", 1, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("t6rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus("t6post", 1, 0, 1, 0);

        // Randomized frames with run-biased bits, gaps, stuffing toggles and restarts.
        lastBit = 1'b0;
        se = 1'b1;
        frameLen = 100;
        for (int n = 0; n < 4000; n++) begin
            logic v, s, b;
            v = ($urandom_range(0, 99) < 80);
            s = v && (frameLen > 60 || $urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 4) se = ~se;
            b = ($urandom_range(0, 99) < 75) ? lastBit : ~lastBit;
            lastBit = b;
            if (s) frameLen = 0;
            else if (v) frameLen++;
            applyStimulus("rand", v, s, se, b);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
